// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants and types for the window-1 draw stages
package vga_pkg;

  localparam logic [10:0] H_DISPLAY_1      = 11'd45;
  localparam logic [10:0] LENGTH_DISPLAY_1 = 11'd512;
  localparam logic [10:0] V_DISPLAY_1      = 11'd530;
  localparam logic [10:0] HEIGHT_DISPLAY_1 = 11'd512;

  localparam int          SAMPLE_W   = 9;
  localparam int          GRID_STEP  = 64;
  localparam logic [11:0] TRACE_RGB  = 12'h0F0;
  localparam logic [11:0] GRID_RGB   = 12'h444;
  localparam logic [11:0] BORDER_RGB = 12'hFFF;

  localparam logic [10:0] WIN1_TOP  = V_DISPLAY_1 - HEIGHT_DISPLAY_1 + 11'd1;
  localparam logic [10:0] GRID_MASK = 11'(GRID_STEP - 1);

  typedef enum logic {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
  } timing_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - two-bank sample store, one sync write port and one sync read port
module trace_ram
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic                wr_bank,
  input  logic [SAMPLE_W-1:0] wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_bank,
  input  logic [SAMPLE_W-1:0] rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [0:(2**(SAMPLE_W+1))-1];
  logic [SAMPLE_W-1:0] rd_data_q;

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
    rd_data_q <= mem[{rd_bank, rd_addr}];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/draw_trace.sv
// rtl/draw_trace.sv - overlays border, grid and captured waveform on display window 1
module draw_trace
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  input  logic        smp_wr_en,
  input  logic [8:0]  smp_wr_addr,
  input  logic [8:0]  smp_wr_data,
  input  logic        frame_done,
  output logic        swap_ack
);

  timing_t             s1_d, s1_q, s2_d, s2_q;
  logic [11:0]         rgb1_d, rgb1_q, rgb2_d, rgb2_q;
  logic [SAMPLE_W-1:0] prev_d, prev_q;
  logic [SAMPLE_W-1:0] rd_addr, cur, prev;
  logic [10:0]         x_off, dy, y_cur, y_prev, y_lo, y_hi;
  logic                in_win, is_trace, is_border, is_grid;

  swap_state_e state_q;
  logic        disp_bank_q, swap_ack_q, vblnk_prev_q, vblnk_rise;

  assign rd_addr = hcount_in[SAMPLE_W-1:0] - H_DISPLAY_1[SAMPLE_W-1:0];

  trace_ram u_ram (
    .clk     (clk),
    .wr_en   (smp_wr_en),
    .wr_bank (~disp_bank_q),
    .wr_addr (smp_wr_addr),
    .wr_data (smp_wr_data),
    .rd_bank (disp_bank_q),
    .rd_addr (rd_addr),
    .rd_data (cur)
  );

  always_comb begin
    s1_d   = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
               vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};
    rgb1_d = rgb_in;
    s2_d   = s1_q;
    prev_d = cur;

    x_off  = s1_q.hcount - H_DISPLAY_1;
    dy     = V_DISPLAY_1 - s1_q.vcount;
    in_win = (s1_q.hcount >= H_DISPLAY_1) && (x_off < LENGTH_DISPLAY_1) &&
             (s1_q.vcount >= WIN1_TOP) && (s1_q.vcount <= V_DISPLAY_1);

    // The first column has no left neighbour, so it connects only to itself.
    prev   = (x_off == 11'd0) ? cur : prev_q;
    y_cur  = V_DISPLAY_1 - {2'b00, cur};
    y_prev = V_DISPLAY_1 - {2'b00, prev};
    y_lo   = (y_cur < y_prev) ? y_cur : y_prev;
    y_hi   = (y_cur < y_prev) ? y_prev : y_cur;

    is_trace  = (s1_q.vcount >= y_lo) && (s1_q.vcount <= y_hi);
    is_border = (x_off == 11'd0) || (x_off == LENGTH_DISPLAY_1 - 11'd1) ||
                (s1_q.vcount == WIN1_TOP) || (s1_q.vcount == V_DISPLAY_1);
    is_grid   = ((x_off & GRID_MASK) == 11'd0) || ((dy & GRID_MASK) == 11'd0);

    if (s1_q.hblnk || s1_q.vblnk) begin
      rgb2_d = 12'h000;
    end else if (!in_win) begin
      rgb2_d = rgb1_q;
    end else if (is_trace) begin
      rgb2_d = TRACE_RGB;
    end else if (is_border) begin
      rgb2_d = BORDER_RGB;
    end else if (is_grid) begin
      rgb2_d = GRID_RGB;
    end else begin
      rgb2_d = rgb1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      rgb1_q <= '0;
      rgb2_q <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rgb1_q <= rgb1_d;
      rgb2_q <= rgb2_d;
      prev_q <= prev_d;
    end
  end

  assign vblnk_rise = vblnk_in && !vblnk_prev_q;

  // Banks only flip on the vblank rising edge, so a frame is always drawn from one bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SWAP_IDLE;
      disp_bank_q  <= 1'b0;
      swap_ack_q   <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      swap_ack_q   <= 1'b0;
      case (state_q)
        SWAP_IDLE: begin
          if (frame_done && vblnk_rise) begin
            disp_bank_q <= ~disp_bank_q;
            swap_ack_q  <= 1'b1;
          end else if (frame_done) begin
            state_q <= SWAP_PEND;
          end
        end
        SWAP_PEND: begin
          if (vblnk_rise) begin
            disp_bank_q <= ~disp_bank_q;
            swap_ack_q  <= 1'b1;
            state_q     <= SWAP_IDLE;
          end
        end
        default: state_q <= SWAP_IDLE;
      endcase
    end
  end

  assign hcount_out = s2_q.hcount;
  assign hsync_out  = s2_q.hsync;
  assign hblnk_out  = s2_q.hblnk;
  assign vcount_out = s2_q.vcount;
  assign vsync_out  = s2_q.vsync;
  assign vblnk_out  = s2_q.vblnk;
  assign rgb_out    = rgb2_q;
  assign swap_ack   = swap_ack_q;

endmodule

// File: tb/tb_draw_trace.sv
// tb/tb_draw_trace.sv - directed self-checking bench for draw_trace
module tb_draw_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        smp_wr_en, frame_done, swap_ack;
  logic [8:0]  smp_wr_addr, smp_wr_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  draw_trace dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out),
    .smp_wr_en(smp_wr_en), .smp_wr_addr(smp_wr_addr), .smp_wr_data(smp_wr_data),
    .frame_done(frame_done), .swap_ack(swap_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_pix(input logic [10:0] h, input logic [10:0] v);
    hcount_in = h; vcount_in = v;
    hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0;
    rgb_in = 12'h123;
  endtask

  // Drives column h-1 then h on consecutive cycles so the trace sees its true left neighbour.
  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] exp,
                     input string tag);
    set_pix(h - 11'd1, v);
    tick();
    set_pix(h, v);
    tick();
    tick();
    check(tag, {52'd0, rgb_out}, {52'd0, exp});
  endtask

  task automatic fill(input logic [8:0] val);
    hblnk_in = 1'b1;
    smp_wr_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      smp_wr_addr = 9'(i);
      smp_wr_data = val;
      tick();
    end
    smp_wr_en = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [8:0] d);
    smp_wr_en = 1'b1; smp_wr_addr = a; smp_wr_data = d;
    tick();
    smp_wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  logic [37:0] exp_hist [0:31];
  logic [37:0] obs_bus;
  int          bad;
  int          acks;

  initial begin
    rst = 1'b1;
    set_pix(11'd700, 11'd300);
    vblnk_in = 1'b0;
    smp_wr_en = 1'b0; smp_wr_addr = '0; smp_wr_data = '0;
    frame_done = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset mid-line
    set_pix(11'd700, 11'd300);
    hsync_in = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    obs_bus = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
    check("reset_outputs_first", {26'd0, obs_bus}, 64'd0);
    tick(); tick();
    obs_bus = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
    check("reset_outputs", {26'd0, obs_bus}, 64'd0);
    check("reset_swap_ack", {63'd0, swap_ack}, 64'd0);
    check("reset_disp_bank", {63'd0, dut.disp_bank_q}, 64'd0);
    rst = 1'b0;

    // Latency: random timing outside the window
    for (int i = 0; i < 24; i++) begin
      hcount_in = 11'($urandom_range(0, 1343));
      vcount_in = 11'($urandom_range(531, 805));
      hsync_in  = 1'($urandom_range(0, 1));
      hblnk_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      vblnk_in  = 1'($urandom_range(0, 1));
      rgb_in    = 12'h123;
      exp_hist[i] = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
                     (hblnk_in || vblnk_in) ? 12'h000 : 12'h123};
      tick();
      if (i >= 1) begin
        obs_bus = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
        check($sformatf("latency_%0d", i), {26'd0, obs_bus}, {26'd0, exp_hist[i-1]});
      end
    end
    vblnk_in = 1'b0;
    tick();

    // Flat trace at 256 in bank 1
    fill(9'd256);
    pulse_done();
    check("flat_no_early_ack", {63'd0, swap_ack}, 64'd0);
    vblnk_in = 1'b1;
    tick();
    check("flat_swap_ack", {63'd0, swap_ack}, 64'd1);
    check("flat_disp_bank", {63'd0, dut.disp_bank_q}, 64'd1);
    tick();
    check("flat_ack_single", {63'd0, swap_ack}, 64'd0);
    vblnk_in = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i <= 512; i++) begin
      set_pix(11'(45 + ((i < 512) ? i : 511)), 11'd274);
      tick();
      if (i >= 1 && rgb_out !== 12'h0F0) bad++;
    end
    check("flat_row274_bad_pixels", 64'(bad), 64'd0);
    pix(11'd45,  11'd300, 12'hFFF, "flat_border_left");
    pix(11'd556, 11'd300, 12'hFFF, "flat_border_right");
    pix(11'd109, 11'd300, 12'h444, "flat_grid_col");
    pix(11'd100, 11'd338, 12'h444, "flat_grid_row");
    pix(11'd100, 11'd300, 12'h123, "flat_background");
    pix(11'd700, 11'd300, 12'h123, "flat_outside");
    pix(11'd300, 11'd19,  12'hFFF, "flat_border_top");

    // Step in bank 0
    fill(9'd256);
    wr(9'd99, 9'd0);
    wr(9'd100, 9'd511);
    pulse_done();
    vblnk_in = 1'b1;
    tick();
    check("step_swap_ack", {63'd0, swap_ack}, 64'd1);
    vblnk_in = 1'b0;
    tick();
    pix(11'd145, 11'd19,  12'h0F0, "step_top");
    pix(11'd145, 11'd300, 12'h0F0, "step_mid");
    pix(11'd145, 11'd530, 12'h0F0, "step_bottom");
    pix(11'd145, 11'd531, 12'h123, "step_below_window");
    pix(11'd146, 11'd100, 12'h0F0, "step_fall_col");
    pix(11'd147, 11'd100, 12'h123, "step_after");

    // Swap timing
    pulse_done();
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (swap_ack) acks++;
    end
    check("swap_wait_no_ack", 64'(acks), 64'd0);
    check("swap_wait_bank", {63'd0, dut.disp_bank_q}, 64'd0);
    vblnk_in = 1'b1;
    tick();
    check("swap_rise_ack", {63'd0, swap_ack}, 64'd1);
    check("swap_rise_bank", {63'd0, dut.disp_bank_q}, 64'd1);
    vblnk_in = 1'b0;
    tick();
    frame_done = 1'b1;
    vblnk_in = 1'b1;
    tick();
    frame_done = 1'b0;
    check("swap_coincident_ack", {63'd0, swap_ack}, 64'd1);
    check("swap_coincident_bank", {63'd0, dut.disp_bank_q}, 64'd0);
    tick();
    check("swap_coincident_single", {63'd0, swap_ack}, 64'd0);
    vblnk_in = 1'b0;
    tick();

    // Isolation and double frame_done
    wr(9'd100, 9'd0);
    pix(11'd145, 11'd200, 12'h0F0, "iso_display_intact");
    pulse_done();
    tick();
    pulse_done();
    vblnk_in = 1'b1;
    tick();
    check("iso_swap_ack", {63'd0, swap_ack}, 64'd1);
    check("iso_swap_bank", {63'd0, dut.disp_bank_q}, 64'd1);
    vblnk_in = 1'b0;
    tick();
    vblnk_in = 1'b1;
    tick();
    check("iso_no_second_ack", {63'd0, swap_ack}, 64'd0);
    check("iso_no_second_bank", {63'd0, dut.disp_bank_q}, 64'd1);
    vblnk_in = 1'b0;
    tick();
    pix(11'd145, 11'd200, 12'h123, "iso_new_col_above");
    pix(11'd145, 11'd400, 12'h0F0, "iso_new_col_below");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
